victim_cache_wb: RTL and testbench
==================================

VICTIM_CACHE_WB -- requirements
Module: victim_cache_wb

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: entry count, power of two, 2..32.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: data bits per line.
REQ-003 SHALL have parameter ADDR_BITS, default 24: line address (tag+index) bits.
REQ-004 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  in  1  start flush (pulse).
REQ-007 SHALL have ports ins_valid_i in 1, ins_ready_o out 1, ins_addr_i in ADDR_BITS, ins_data_i in LINE_WIDTH, ins_dirty_i in 1: line evicted from L1 into the victim cache.
REQ-008 SHALL have ports lkp_valid_i in 1, lkp_addr_i in ADDR_BITS, lkp_take_i in 1: L1 miss probe; take means hit line moves back to L1.
REQ-009 SHALL have ports lkp_hit_o out 1, lkp_data_o out LINE_WIDTH, lkp_dirty_o out 1: combinational probe result.
REQ-010 SHALL have ports wb_valid_o out 1, wb_ready_i in 1, wb_addr_o out ADDR_BITS, wb_data_o out LINE_WIDTH: dirty-line writeback to memory.
REQ-011 SHALL have port flush_done_o  out  1  one-cycle pulse when flush completes.

Function
REQ-012 SHALL implement FSM IDLE, EVICT, FLUSH: IDLE->EVICT on dirty replacement; EVICT->IDLE on wb handshake; IDLE->FLUSH on flush_i; FLUSH->IDLE after last entry.
REQ-013 SHALL assert lkp_hit_o when lkp_valid_i and a valid entry matches lkp_addr_i, outside FLUSH; on miss, lkp_data_o and lkp_dirty_o SHALL be 0.
REQ-014 SHALL invalidate the hit entry at the clock edge when lkp_hit_o and lkp_take_i are both high.
REQ-015 SHALL accept an insert when ins_valid_i and ins_ready_o; ins_ready_o is high only in IDLE.
REQ-016 On an insert address match, SHALL overwrite the data and set dirty to stored dirty OR ins_dirty_i, with no new allocation.
REQ-017 Otherwise SHALL allocate the lowest-index invalid entry.
REQ-018 When all entries are valid, SHALL select the replacement victim per REQ-029/030; a clean victim SHALL be overwritten in the same cycle.
REQ-019 A dirty victim SHALL be copied to the wb register and overwritten by the insert in the same cycle, then the FSM enters EVICT.
REQ-020 wb_valid_o SHALL stay high with stable wb_addr_o and wb_data_o until wb_ready_i is sampled high.
REQ-021 On insert and take of the same address in one cycle, the insert SHALL win and the entry SHALL remain valid with the new data.
REQ-022 On insert and take of different entries in one cycle, both SHALL take effect, and the freed slot SHALL not be chosen for that insert.
REQ-023 FLUSH SHALL visit entries 0..NUM_ENTRIES-1, one per cycle; each dirty valid entry SHALL be written back and the scan SHALL stall until wb_ready_i; every entry SHALL be invalidated.
REQ-024 flush_i in EVICT SHALL be latched and FLUSH entered after the handshake; flush_i in FLUSH SHALL be ignored.
REQ-025 flush_done_o SHALL pulse for one cycle on the FLUSH->IDLE transition.

Reset
REQ-026 Reset SHALL clear all valid and dirty bits, the replacement state, and the pending flush, and set the FSM to IDLE.
REQ-027 During and after reset: ins_ready_o=1, wb_valid_o=0, flush_done_o=0, lkp_hit_o=0; the data array SHALL not be reset.
REQ-028 Reset during EVICT or FLUSH SHALL drop the pending writeback without a handshake.

Configuration
REQ-029 With VICTIM_LRU_EN defined: true LRU via per-entry age counters; an insert or a lookup hit makes that entry most recent; the victim is the least-recently-used entry.
REQ-030 Without VICTIM_LRU_EN: FIFO replacement with a round-robin pointer that advances modulo NUM_ENTRIES only on a full-cache replacement; no age state is synthesised.

Verification
REQ-031 Insert A=0x10 (data 0x1, clean), then probe 0x10 -> lkp_hit_o=1, lkp_data_o=0x1, lkp_dirty_o=0; probe with take -> next cycle probe misses.
REQ-032 Fill 8 entries with dirty lines 0x0..0x7, insert 0x8 with wb_ready_i=0 for 3 cycles -> wb_valid_o=1 with wb_addr_o=0x0 (FIFO), ins_ready_o=0 until the handshake.
REQ-033 Under VICTIM_LRU_EN, fill 0x0..0x7, probe 0x0, insert 0x8 -> 0x1 evicted; 0x0 still hits.
REQ-034 Three dirty and two clean entries, pulse flush_i -> exactly 3 wb handshakes, flush_done_o pulses once, all probes miss.
REQ-035 Insert 0x5 dirty, reinsert 0x5 clean with new data -> single entry, dirty=1, new data; same-cycle insert/take of 0x5 -> remains hit.

Source files
------------

// File: rtl/victim_cache_wb.sv
// Victim cache with dirty-line writeback, behind an L1 data cache.
// Holds NUM_ENTRIES fully-associative lines that L1 has evicted.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush_i           start a flush of every entry (pulse)
//   ins_*             line evicted from L1 (valid/ready handshake)
//   lkp_*             L1 miss probe; combinational hit/data/dirty result,
//                     lkp_take_i moves the hit line back to L1
//   wb_*              dirty-line writeback to memory (valid/ready)
//   flush_done_o      one-cycle pulse when a flush completes
//
// Build option: define VICTIM_LRU_EN for true-LRU replacement; otherwise
// a round-robin FIFO pointer picks the victim.

module victim_cache_wb #(
   parameter int NUM_ENTRIES = 8,
   parameter int LINE_WIDTH  = 128,
   parameter int ADDR_BITS   = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  ins_valid_i,
   output logic                  ins_ready_o,
   input  logic [ADDR_BITS-1:0]  ins_addr_i,
   input  logic [LINE_WIDTH-1:0] ins_data_i,
   input  logic                  ins_dirty_i,
   input  logic                  lkp_valid_i,
   input  logic [ADDR_BITS-1:0]  lkp_addr_i,
   input  logic                  lkp_take_i,
   output logic                  lkp_hit_o,
   output logic [LINE_WIDTH-1:0] lkp_data_o,
   output logic                  lkp_dirty_o,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [ADDR_BITS-1:0]  wb_addr_o,
   output logic [LINE_WIDTH-1:0] wb_data_o,
   output logic                  flush_done_o
);

   localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   typedef logic [IW-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE,
      EVICT,
      FLUSH
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [NUM_ENTRIES-1:0] valid_q;
   logic [NUM_ENTRIES-1:0] dirty_q;
   logic [ADDR_BITS-1:0]   tag_q  [NUM_ENTRIES];
   logic [LINE_WIDTH-1:0]  data_q [NUM_ENTRIES];

   logic                  wb_valid_q;
   logic [ADDR_BITS-1:0]  wb_addr_q;
   logic [LINE_WIDTH-1:0] wb_data_q;
   logic                  flush_pend_q;
   idx_t                  fl_idx_q;

   logic lkp_any;
   idx_t lkp_idx;
   logic ins_hit;
   idx_t ins_hit_idx;
   logic free_any;
   idx_t free_idx;
   idx_t vic_idx;
   idx_t ins_idx;

   logic ins_fire;
   logic take_fire;
   logic repl;
   logic evict_dirty;
   logic fl_cur_dirty;
   logic fl_load;
   logic fl_adv;
   logic fl_clear;

   // Probe match; the loop runs downward so the lowest index wins.
   always_comb begin
      lkp_any = 1'b0;
      lkp_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && tag_q[i] == lkp_addr_i) begin
            lkp_any = 1'b1;
            lkp_idx = idx_t'(i);
         end
      end
   end

   always_comb begin
      ins_hit     = 1'b0;
      ins_hit_idx = '0;
      free_any    = 1'b0;
      free_idx    = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && tag_q[i] == ins_addr_i) begin
            ins_hit     = 1'b1;
            ins_hit_idx = idx_t'(i);
         end
         if (!valid_q[i]) begin
            free_any = 1'b1;
            free_idx = idx_t'(i);
         end
      end
   end

   assign lkp_hit_o   = lkp_valid_i && (state_q != FLUSH) && lkp_any;
   assign lkp_data_o  = lkp_hit_o ? data_q[lkp_idx] : '0;
   assign lkp_dirty_o = lkp_hit_o ? dirty_q[lkp_idx] : 1'b0;

   assign ins_ready_o = (state_q == IDLE);
   assign ins_fire    = ins_valid_i && ins_ready_o;
   assign take_fire   = lkp_hit_o && lkp_take_i;

   // Free slots come from the pre-edge valid bits, so a slot freed by a
   // same-cycle take is never picked for this insert.
   always_comb begin
      if (ins_hit) begin
         ins_idx = ins_hit_idx;
      end else if (free_any) begin
         ins_idx = free_idx;
      end else begin
         ins_idx = vic_idx;
      end
   end

   assign repl = ins_fire && !ins_hit && !free_any;

   // A victim that is simultaneously taken back by L1 needs no writeback.
   assign evict_dirty = repl && dirty_q[vic_idx]
                        && !(take_fire && lkp_idx == vic_idx);

   assign fl_cur_dirty = valid_q[fl_idx_q] && dirty_q[fl_idx_q];

`ifdef VICTIM_LRU_EN
   // Ages form a permutation of 0..N-1; 0 is most recent.
   idx_t age_q [NUM_ENTRIES];
   idx_t age_d [NUM_ENTRIES];
   idx_t hit_age;
   idx_t ins_age;

   always_comb begin
      vic_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (age_q[i] == idx_t'(NUM_ENTRIES - 1)) begin
            vic_idx = idx_t'(i);
         end
      end
   end

   // Probe touch first, insert touch last so the insert ends up newest.
   always_comb begin
      age_d   = age_q;
      hit_age = '0;
      ins_age = '0;
      if (lkp_hit_o) begin
         hit_age = age_d[lkp_idx];
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (age_d[j] < hit_age) begin
               age_d[j] = age_d[j] + idx_t'(1);
            end
         end
         age_d[lkp_idx] = '0;
      end
      if (ins_fire) begin
         ins_age = age_d[ins_idx];
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (age_d[j] < ins_age) begin
               age_d[j] = age_d[j] + idx_t'(1);
            end
         end
         age_d[ins_idx] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_q[i] <= idx_t'(i);
         end
      end else begin
         age_q <= age_d;
      end
   end
`else
   idx_t fifo_q;

   assign vic_idx = fifo_q;

   // NUM_ENTRIES is a power of two, so the increment wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_q <= '0;
      end else if (repl) begin
         fifo_q <= fifo_q + idx_t'(1);
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      flush_done_o = 1'b0;
      fl_load      = 1'b0;
      fl_adv       = 1'b0;
      fl_clear     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (evict_dirty) begin
               state_d = EVICT;
            end else if (flush_i) begin
               state_d = FLUSH;
            end
         end
         EVICT: begin
            if (wb_ready_i) begin
               state_d = (flush_pend_q || flush_i) ? FLUSH : IDLE;
            end
         end
         FLUSH: begin
            // A dirty entry is loaded into the wb register and cleared;
            // the scan then holds until memory accepts it.
            if (wb_valid_q) begin
               fl_adv = wb_ready_i;
            end else begin
               fl_clear = 1'b1;
               fl_load  = fl_cur_dirty;
               fl_adv   = !fl_cur_dirty;
            end
            if (fl_adv && fl_idx_q == idx_t'(NUM_ENTRIES - 1)) begin
               state_d      = IDLE;
               flush_done_o = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
         wb_data_q    <= '0;
         flush_pend_q <= 1'b0;
         fl_idx_q     <= '0;
      end else begin
         state_q <= state_d;

         if (take_fire) begin
            valid_q[lkp_idx] <= 1'b0;
         end
         if (ins_fire) begin
            valid_q[ins_idx] <= 1'b1;
            dirty_q[ins_idx] <= (ins_hit && dirty_q[ins_idx])
                                || ins_dirty_i;
         end
         if (fl_clear) begin
            valid_q[fl_idx_q] <= 1'b0;
            dirty_q[fl_idx_q] <= 1'b0;
         end

         if (evict_dirty) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= tag_q[vic_idx];
            wb_data_q  <= data_q[vic_idx];
         end else if (fl_load) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= tag_q[fl_idx_q];
            wb_data_q  <= data_q[fl_idx_q];
         end else if (wb_valid_q && wb_ready_i) begin
            wb_valid_q <= 1'b0;
         end

         if (state_q == IDLE && flush_i && evict_dirty) begin
            flush_pend_q <= 1'b1;
         end else if (state_q == EVICT) begin
            if (wb_ready_i) begin
               flush_pend_q <= 1'b0;
            end else if (flush_i) begin
               flush_pend_q <= 1'b1;
            end
         end

         if (fl_adv) begin
            fl_idx_q <= fl_idx_q + idx_t'(1);
         end
      end
   end

   // Line storage carries no reset.
   always_ff @(posedge clk) begin
      if (ins_fire) begin
         tag_q[ins_idx]  <= ins_addr_i;
         data_q[ins_idx] <= ins_data_i;
      end
   end

   assign wb_valid_o = wb_valid_q;
   assign wb_addr_o  = wb_addr_q;
   assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_victim_cache_wb.sv
// Self-checking bench for victim_cache_wb.
// Expected writebacks are queued at stimulus time and popped per handshake.

module tb_victim_cache_wb;

   localparam int N  = 8;
   localparam int LW = 128;
   localparam int AB = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          ins_valid_i;
   logic          ins_ready_o;
   logic [AB-1:0] ins_addr_i;
   logic [LW-1:0] ins_data_i;
   logic          ins_dirty_i;
   logic          lkp_valid_i;
   logic [AB-1:0] lkp_addr_i;
   logic          lkp_take_i;
   logic          lkp_hit_o;
   logic [LW-1:0] lkp_data_o;
   logic          lkp_dirty_o;
   logic          wb_valid_o;
   logic          wb_ready_i;
   logic [AB-1:0] wb_addr_o;
   logic [LW-1:0] wb_data_o;
   logic          flush_done_o;

   always #5 clk = ~clk;

   victim_cache_wb #(
      .NUM_ENTRIES(N),
      .LINE_WIDTH (LW),
      .ADDR_BITS  (AB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .ins_valid_i (ins_valid_i),
      .ins_ready_o (ins_ready_o),
      .ins_addr_i  (ins_addr_i),
      .ins_data_i  (ins_data_i),
      .ins_dirty_i (ins_dirty_i),
      .lkp_valid_i (lkp_valid_i),
      .lkp_addr_i  (lkp_addr_i),
      .lkp_take_i  (lkp_take_i),
      .lkp_hit_o   (lkp_hit_o),
      .lkp_data_o  (lkp_data_o),
      .lkp_dirty_o (lkp_dirty_o),
      .wb_valid_o  (wb_valid_o),
      .wb_ready_i  (wb_ready_i),
      .wb_addr_o   (wb_addr_o),
      .wb_data_o   (wb_data_o),
      .flush_done_o(flush_done_o)
   );

   typedef struct packed {
      logic [AB-1:0] a;
      logic [LW-1:0] d;
   } wb_t;

   wb_t exp_q[$];
   wb_t e;

   int n_checks = 0;
   int n_err    = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;
   int hs0;

   logic          pend_q = 1'b0;
   logic [AB-1:0] pa;
   logic [LW-1:0] pd;

   task automatic check(input string tag,
                        input logic [LW-1:0] got,
                        input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void exp_wb(input int a, input int d);
      wb_t w;
      w.a = AB'(a);
      w.d = LW'(d);
      exp_q.push_back(w);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (pend_q) begin
            check("wb_hold_valid", LW'(wb_valid_o), 1);
            check("wb_hold_addr", LW'(wb_addr_o), LW'(pa));
            check("wb_hold_data", wb_data_o, pd);
         end
         if (flush_done_o) done_cnt++;
         if (wb_valid_o && wb_ready_i) begin
            hs_cnt++;
            check("wb_q_nonempty", LW'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("wb_addr", LW'(wb_addr_o), LW'(e.a));
               check("wb_data", wb_data_o, e.d);
            end
         end
         pend_q = wb_valid_o && !wb_ready_i;
         pa     = wb_addr_o;
         pd     = wb_data_o;
      end else begin
         pend_q = 1'b0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ins(input int a, input int d, input logic dty);
      int t;
      t = 0;
      ins_valid_i = 1'b1;
      ins_addr_i  = AB'(a);
      ins_data_i  = LW'(d);
      ins_dirty_i = dty;
      while (!ins_ready_o && t < 50) begin
         cyc();
         t++;
      end
      check($sformatf("ins_ready_%0h", a), LW'(t < 50), 1);
      cyc();
      ins_valid_i = 1'b0;
   endtask

   task automatic probe(input int a, input logic take,
                        input logic eh, input int ed, input logic edt);
      lkp_valid_i = 1'b1;
      lkp_addr_i  = AB'(a);
      lkp_take_i  = take;
      #1;
      check($sformatf("hit_%0h", a), LW'(lkp_hit_o), LW'(eh));
      check($sformatf("data_%0h", a), lkp_data_o, LW'(ed));
      check($sformatf("dirty_%0h", a), LW'(lkp_dirty_o), LW'(edt));
      cyc();
      lkp_valid_i = 1'b0;
      lkp_take_i  = 1'b0;
   endtask

   task automatic run_flush(input int n_hs);
      int d0;
      int h0;
      int t;
      d0 = done_cnt;
      h0 = hs_cnt;
      t  = 0;
      if (ins_ready_o) begin
         flush_i = 1'b1;
         cyc();
         flush_i = 1'b0;
      end
      while (done_cnt == d0 && t < 300) begin
         wb_ready_i = 1'($urandom_range(0, 1));
         cyc();
         t++;
      end
      wb_ready_i = 1'b1;
      cyc();
      cyc();
      check("flush_done_cnt", LW'(done_cnt - d0), 1);
      check("flush_hs_cnt", LW'(hs_cnt - h0), LW'(n_hs));
      check("flush_q_empty", LW'(exp_q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: sim time %0t exceeded", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b0;
      flush_i     = 1'b0;
      ins_valid_i = 1'b0;
      ins_addr_i  = '0;
      ins_data_i  = '0;
      ins_dirty_i = 1'b0;
      lkp_valid_i = 1'b1;
      lkp_addr_i  = '0;
      lkp_take_i  = 1'b0;
      wb_ready_i  = 1'b1;
      cyc();
      cyc();
      check("rst_ins_ready", LW'(ins_ready_o), 1);
      check("rst_wb_valid", LW'(wb_valid_o), 0);
      check("rst_flush_done", LW'(flush_done_o), 0);
      check("rst_hit", LW'(lkp_hit_o), 0);
      rst = 1'b1;
      cyc();
      check("post_rst_hit", LW'(lkp_hit_o), 0);
      check("post_rst_ready", LW'(ins_ready_o), 1);
      lkp_valid_i = 1'b0;

      // basic insert, probe, take
      ins('h10, 'h1, 1'b0);
      probe('h10, 1'b0, 1'b1, 'h1, 1'b0);
      probe('h10, 1'b1, 1'b1, 'h1, 1'b0);
      probe('h10, 1'b0, 1'b0, 0, 1'b0);

      // reinsert merges dirty; same-cycle insert+take keeps entry
      ins('h5, 'hAA, 1'b1);
      ins('h5, 'hBB, 1'b0);
      probe('h5, 1'b0, 1'b1, 'hBB, 1'b1);
      ins_valid_i = 1'b1;
      ins_addr_i  = AB'('h5);
      ins_data_i  = LW'('hCC);
      ins_dirty_i = 1'b0;
      lkp_valid_i = 1'b1;
      lkp_addr_i  = AB'('h5);
      lkp_take_i  = 1'b1;
      #1;
      check("same_take_hit", LW'(lkp_hit_o), 1);
      cyc();
      ins_valid_i = 1'b0;
      lkp_valid_i = 1'b0;
      lkp_take_i  = 1'b0;
      probe('h5, 1'b0, 1'b1, 'hCC, 1'b1);
      exp_wb('h5, 'hCC);
      run_flush(1);
      probe('h5, 1'b0, 1'b0, 0, 1'b0);

      // three dirty + two clean, then flush
      for (int i = 0; i < 3; i++) begin
         ins('h20 + i, 'h120 + i, 1'b1);
         exp_wb('h20 + i, 'h120 + i);
      end
      ins('h30, 'h130, 1'b0);
      ins('h31, 'h131, 1'b0);
      run_flush(3);
      for (int i = 0; i < 3; i++) begin
         probe('h20 + i, 1'b0, 1'b0, 0, 1'b0);
      end
      probe('h30, 1'b0, 1'b0, 0, 1'b0);
      probe('h31, 1'b0, 1'b0, 0, 1'b0);

      // full cache, dirty victim with stalled memory
      for (int i = 0; i < N; i++) begin
         ins(i, 'h100 + i, 1'b1);
      end
      wb_ready_i = 1'b0;
      exp_wb('h0, 'h100);
      ins('h8, 'h108, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("evict_valid", LW'(wb_valid_o), 1);
         check("evict_addr", LW'(wb_addr_o), 0);
         check("evict_ready", LW'(ins_ready_o), 0);
         cyc();
      end
      wb_ready_i = 1'b1;
      cyc();
      check("evict_done_ready", LW'(ins_ready_o), 1);
      check("evict_done_valid", LW'(wb_valid_o), 0);
      probe('h8, 1'b0, 1'b1, 'h108, 1'b1);
      probe('h0, 1'b0, 1'b0, 0, 1'b0);

      // replacement order
      exp_wb('h1, 'h101);
      ins('h9, 'h109, 1'b0);
      probe('h2, 1'b0, 1'b1, 'h102, 1'b1);
`ifdef VICTIM_LRU_EN
      exp_wb('h3, 'h103);
`else
      exp_wb('h2, 'h102);
`endif
      ins('hA, 'h10A, 1'b1);
`ifdef VICTIM_LRU_EN
      probe('h2, 1'b0, 1'b1, 'h102, 1'b1);
      probe('h3, 1'b0, 1'b0, 0, 1'b0);
`else
      probe('h2, 1'b0, 1'b0, 0, 1'b0);
      probe('h3, 1'b0, 1'b1, 'h103, 1'b1);
`endif

      // insert and take of different entries together
`ifdef VICTIM_LRU_EN
      exp_wb('h4, 'h104);
`else
      exp_wb('h3, 'h103);
`endif
      check("ins_ready_pair", LW'(ins_ready_o), 1);
      ins_valid_i = 1'b1;
      ins_addr_i  = AB'('hB);
      ins_data_i  = LW'('h10B);
      ins_dirty_i = 1'b0;
      lkp_valid_i = 1'b1;
      lkp_addr_i  = AB'('h6);
      lkp_take_i  = 1'b1;
      #1;
      check("pair_hit", LW'(lkp_hit_o), 1);
      check("pair_data", lkp_data_o, LW'('h106));
      cyc();
      ins_valid_i = 1'b0;
      lkp_valid_i = 1'b0;
      lkp_take_i  = 1'b0;
      probe('h6, 1'b0, 1'b0, 0, 1'b0);
      probe('hB, 1'b0, 1'b1, 'h10B, 1'b0);
      hs0 = hs_cnt;
      ins('hC, 'h10C, 1'b0);
      cyc();
      check("freed_slot_hs", LW'(hs_cnt - hs0), 0);
      check("freed_slot_q", LW'(exp_q.size()), 0);

      // flush requested while a writeback is stalled
      wb_ready_i = 1'b0;
`ifdef VICTIM_LRU_EN
      exp_wb('h5, 'h105);
`else
      exp_wb('h4, 'h104);
`endif
      ins('hD, 'h10D, 1'b1);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      cyc();
      check("evflush_valid", LW'(wb_valid_o), 1);
      check("evflush_ready", LW'(ins_ready_o), 0);
`ifdef VICTIM_LRU_EN
      exp_wb('h8, 'h108);
      exp_wb('h2, 'h102);
      exp_wb('hA, 'h10A);
      exp_wb('hD, 'h10D);
      exp_wb('h7, 'h107);
`else
      exp_wb('h8, 'h108);
      exp_wb('hA, 'h10A);
      exp_wb('hD, 'h10D);
      exp_wb('h5, 'h105);
      exp_wb('h7, 'h107);
`endif
      run_flush(6);
      probe('h8, 1'b0, 1'b0, 0, 1'b0);
      probe('hD, 1'b0, 1'b0, 0, 1'b0);
      probe('h9, 1'b0, 1'b0, 0, 1'b0);

      // reset during EVICT drops the writeback
      for (int i = 0; i < N; i++) begin
         ins('h40 + i, 'h140 + i, 1'b1);
      end
      wb_ready_i = 1'b0;
      ins('h50, 'h150, 1'b1);
      check("pre_rst_valid", LW'(wb_valid_o), 1);
      hs0 = hs_cnt;
      rst = 1'b0;
      lkp_valid_i = 1'b1;
      lkp_addr_i  = AB'('h50);
      #1;
      check("mid_rst_valid", LW'(wb_valid_o), 0);
      check("mid_rst_ready", LW'(ins_ready_o), 1);
      check("mid_rst_hit", LW'(lkp_hit_o), 0);
      cyc();
      cyc();
      rst = 1'b1;
      wb_ready_i = 1'b1;
      cyc();
      cyc();
      check("post_rst_hs", LW'(hs_cnt - hs0), 0);
      check("post_rst_miss", LW'(lkp_hit_o), 0);
      lkp_valid_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
